// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch queue.
//   FQ_WORDSZ / FQ_INSTSZ / FQ_DEPTH : default PC width, instruction width, depth
//   fetch_entry_t                    : one queue slot {pc, instr} at default widths
package fetch_pkg;

  localparam int FQ_WORDSZ = 64;
  localparam int FQ_INSTSZ = 32;
  localparam int FQ_DEPTH  = 4;

  typedef struct packed {
    logic [FQ_WORDSZ-1:0] pc;
    logic [FQ_INSTSZ-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of {pc, instr} pairs between the instruction
// cache and the decoder, with its own sequential fetch PC and a redirect path.
//   clk, reset (async, active-low), entry : clock, reset, program entry PC
//   fetch_pc, fetch_req                   : address and request to the cache
//   in_valid, in_instr, in_ready          : returned instruction / accept
//   out_valid, out_pc, out_instr, out_ready : head entry to the decoder
//   flush, flush_pc                       : redirect; empties the queue
//   count                                 : current occupancy 0..DEPTH
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WORDSZ = FQ_WORDSZ,
  parameter int INSTSZ = FQ_INSTSZ,
  parameter int DEPTH  = FQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WORDSZ-1:0]          entry,
  output logic [WORDSZ-1:0]          fetch_pc,
  output logic                       fetch_req,
  input  logic                       in_valid,
  input  logic [INSTSZ-1:0]          in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WORDSZ-1:0]          out_pc,
  output logic [INSTSZ-1:0]          out_instr,
  input  logic                       out_ready,
  input  logic                       flush,
  input  logic [WORDSZ-1:0]          flush_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Local slot type so non-default widths still work; matches fetch_entry_t
  // at the default parameters.
  typedef struct packed {
    logic [WORDSZ-1:0] pc;
    logic [INSTSZ-1:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          enq;
  logic          deq;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign fetch_req = in_ready & ~flush;
  assign enq       = in_valid & in_ready & ~flush;
  assign deq       = out_valid & out_ready & ~flush;
  assign out_pc    = mem[head].pc;
  assign out_instr = mem[head].instr;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= entry;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= flush_pc;
    end else begin
      if (enq) begin
        tail     <= tail + 1'b1;
        fetch_pc <= fetch_pc + WORDSZ'(4);
      end
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale slots are never visible since out_valid
  // only covers written entries.
  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= '{pc: fetch_pc, instr: in_instr};
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic [63:0] fetch_pc;
  logic        fetch_req;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        flush;
  logic [63:0] flush_pc;
  logic [2:0]  count;

  fetch_queue #(.WORDSZ(64), .INSTSZ(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .entry(entry),
    .fetch_pc(fetch_pc), .fetch_req(fetch_req),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .flush(flush), .flush_pc(flush_pc),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {pc, instr} plus the next fetch address.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } m_entry_t;

  m_entry_t    mq[$];
  logic [63:0] m_pc;

  always @(posedge clk) begin
    bit do_enq, do_deq;
    if (!reset) begin
      mq.delete();
      m_pc = entry;
    end else begin
      if (flush) begin
        mq.delete();
        m_pc = flush_pc;
      end else begin
        do_enq = in_valid && (mq.size() < DEPTH);
        do_deq = out_ready && (mq.size() > 0);
        if (do_deq) void'(mq.pop_front());
        if (do_enq) begin
          mq.push_back('{pc: m_pc, instr: in_instr});
          m_pc = m_pc + 64'd4;
        end
      end
      #2;
      if (reset) begin
        chk("count", 64'(count), 64'(mq.size()));
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        chk("fetch_req", 64'(fetch_req), 64'((mq.size() < DEPTH) && !flush));
        chk("fetch_pc", fetch_pc, m_pc);
        if (mq.size() > 0) begin
          chk("out_pc", out_pc, mq[0].pc);
          chk("out_instr", 64'(out_instr), 64'(mq[0].instr));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; entry = 64'h1000;
    in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    flush = 1'b0; flush_pc = '0;
    cyc(2);
    chk("rst_fetch_pc", fetch_pc, 64'h1000);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_fetch_req", 64'(fetch_req), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    reset = 1'b1;
    cyc(1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_fetch_pc", fetch_pc, 64'h1000);

    // fill
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = 32'hA0 + 32'(i);
      cyc(1);
    end
    in_valid = 1'b0;
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_fetch_req", 64'(fetch_req), 64'd0);
    chk("fill_fetch_pc", fetch_pc, 64'h1010);
    chk("fill_out_pc", out_pc, 64'h1000);
    chk("fill_out_instr", 64'(out_instr), 64'hA0);

    // full with both sides active: only dequeue
    in_valid = 1'b1; in_instr = 32'hB0; out_ready = 1'b1;
    cyc(1);
    chk("full_count", 64'(count), 64'd3);
    chk("full_out_pc", out_pc, 64'h1004);
    chk("full_fetch_pc", fetch_pc, 64'h1010);

    in_valid = 1'b0;
    cyc(1);
    chk("drain_count", 64'(count), 64'd2);

    // steady enq+deq across the wrap boundary
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_instr = 32'hC0 + 32'(i); out_ready = 1'b1;
      cyc(1);
      chk("steady_count", 64'(count), 64'd2);
    end
    chk("wrap_out_pc", out_pc, 64'h1020);
    chk("wrap_out_instr", 64'(out_instr), 64'hC4);
    chk("wrap_fetch_pc", fetch_pc, 64'h1028);

    out_ready = 1'b0; in_instr = 32'hC6;
    cyc(1);
    chk("pre_flush_count", 64'(count), 64'd3);

    // flush beats same-cycle enqueue and dequeue
    flush = 1'b1; flush_pc = 64'h2000; in_valid = 1'b1; in_instr = 32'hEE; out_ready = 1'b1;
    #1 chk("flush_fetch_req", 64'(fetch_req), 64'd0);
    cyc(1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_fetch_pc", fetch_pc, 64'h2000);

    in_valid = 1'b1; in_instr = 32'hD0;
    cyc(1);
    in_instr = 32'hD1;
    cyc(1);
    in_valid = 1'b0;
    chk("redir_out_pc", out_pc, 64'h2000);
    chk("redir_out_instr", 64'(out_instr), 64'hD0);
    chk("redir_count", 64'(count), 64'd2);

    // asynchronous reset mid-stream
    in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'hF0;
    #2 reset = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_fetch_pc", fetch_pc, 64'h1000);
    in_valid = 1'b0; out_ready = 1'b0;
    cyc(2);
    reset = 1'b1;

    // mixed traffic, occasional flush including at full and empty
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) == 0);
      in_instr  = $urandom;
      flush     = 1'($urandom_range(0, 15) == 0);
      flush_pc  = 64'h3000 + 64'(16 * i);
      cyc(1);
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter WORDSZ, default 64, PC width.
REQ-002 SHALL have parameter INSTSZ, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port entry  input  WORDSZ  program entry PC, stable while reset asserted.
REQ-007 SHALL have ports fetch_pc  output  WORDSZ  address presented to instruction cache; fetch_req  output  1  fetch request.
REQ-008 SHALL have ports in_valid  input  1  cache returned instruction; in_instr  input  INSTSZ  instruction word; in_ready  output  1  queue can accept.
REQ-009 SHALL have ports out_valid  output  1  head entry valid; out_pc  output  WORDSZ  head PC; out_instr  output  INSTSZ  head instruction; out_ready  input  1  decoder consumes head.
REQ-010 SHALL have ports flush  input  1  redirect (jump/flush resolved downstream); flush_pc  input  WORDSZ  redirect target.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-012 SHALL hold DEPTH entries of {pc, instr} in a circular buffer with head/tail pointers wrapping modulo DEPTH and a count in 0..DEPTH.
REQ-013 SHALL drive in_ready = (count < DEPTH); no enqueue when full, even with simultaneous dequeue.
REQ-014 SHALL enqueue {fetch_pc, in_instr} at tail on a rising edge where in_valid & in_ready & !flush, then advance fetch_pc by 4 (modulo 2^WORDSZ).
REQ-015 SHALL dequeue head on a rising edge where out_valid & out_ready & !flush.
REQ-016 SHALL, on simultaneous enqueue and dequeue, leave count unchanged and advance both pointers.
REQ-017 SHALL drive out_valid = (count != 0); no combinational bypass, so enqueue-to-out_valid latency is one cycle.
REQ-018 SHALL drive out_pc/out_instr from the head entry combinationally; values are don't-care when out_valid=0.
REQ-019 SHALL drive fetch_req = in_ready & !flush; fetch_pc held constant while fetch_req=0 or no in_valid.
REQ-020 SHALL, on a rising edge with flush=1, reset head, tail, count to 0 and load fetch_pc <= flush_pc; a same-cycle enqueue or dequeue is discarded.
REQ-021 SHALL treat flush as top priority over all other events, including when full or empty.
REQ-022 SHALL never change occupancy by more than one per cycle and never overflow or underflow.

Reset
REQ-023 SHALL, while reset=0, asynchronously force head=0, tail=0, count=0, fetch_pc=entry.
REQ-024 SHALL, during and immediately after reset, present out_valid=0, in_ready=1, fetch_req=1, count=0.
REQ-025 SHALL discard any in-progress enqueue/dequeue when reset asserts mid-operation; storage contents need not be cleared.

Structure
REQ-026 SHALL place the entry struct typedef {pc, instr} and default DEPTH constant in shared package fetch_pkg.
REQ-027 SHALL be a single module; no sub-module is required (storage is an inferred register array).

Verification
REQ-028 Reset with entry=0x1000 -> fetch_pc=0x1000, out_valid=0, in_ready=1, count=0.
REQ-029 Four consecutive in_valid (instr 0xA0..0xA3), out_ready=0 -> count=4, in_ready=0, fetch_pc=0x1010, out_pc=0x1000, out_instr=0xA0.
REQ-030 Full queue, in_valid=1, out_ready=1 for one cycle -> only dequeue, count=3, next head out_pc=0x1004.
REQ-031 count=2, in_valid=1 and out_ready=1 same cycle -> count stays 2, tail wraps correctly across DEPTH boundary over 6 cycles.
REQ-032 count=3, flush=1 with flush_pc=0x2000, in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0, fetch_pc=0x2000, no entry written.
REQ-033 Reset asserted mid-stream at count=2 -> immediately count=0, out_valid=0, fetch_pc=entry.
